// File: rtl/i2s_pkg.sv
// Shared types for the I2S frame FIFO: default sample width, channel encoding,
// and the left/right pairing state.
package i2s_pkg;

  localparam int DATA_SIZE_DEF = 24;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } pair_state_t;

endpackage

// File: rtl/i2s_frame_fifo_if.sv
// Stereo frame stream leaving the FIFO towards the consumer.
interface i2s_frame_fifo_if #(
  parameter int DATA_SIZE = 24
);
  // A frame transfers on a cycle where m_valid and m_ready are both high.
  // While m_valid=1 and m_ready=0 the frame data holds steady, and m_valid
  // never drops until the frame has been taken.
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_left;
  logic [DATA_SIZE-1:0] m_right;

  modport master (output m_valid, output m_left, output m_right, input m_ready);
  modport slave  (input m_valid, input m_left, input m_right, output m_ready);
endinterface

// File: rtl/i2s_frame_fifo_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read and wrap-bit
// pointers so that level = wr_ptr - rd_ptr.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == (AW + 1)'(DEPTH));
  assign o_empty = (o_level == '0);

  // While full, a simultaneous pop frees the slot the push lands in.
  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  // Head data is forced to zero when empty so nothing stale leaks out.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_frame_fifo.sv
// Pairs mono samples from the I2S receiver into left/right frames, buffers them
// in a FIFO and flags dropped frames and pairing errors.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_SIZE-1:0]   sample_data,
  input  logic                   sample_valid,
  input  logic                   sample_ws,
  input  logic                   clear,
  i2s_frame_fifo_if.master       m,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   sync_err,
  output logic [7:0]             err_count,
  output pair_state_t            dbg_state
);
  pair_state_t            r_state;
  logic                   r_valid_q;
  logic [DATA_SIZE-1:0]   r_left_hold;
  logic                   r_overflow;
  logic                   r_sync_err;
  logic [7:0]             r_err_count;

  logic                   w_cap;
  channel_t               w_ch;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_drop;
  logic                   w_serr;
  logic [2*DATA_SIZE-1:0] w_rdata;

  assign w_cap = sample_valid & ~r_valid_q;
  // Upstream flips ws in the same cycle it raises valid, so the channel of the
  // finished sample is the inverse of the ws seen now.
  assign w_ch  = channel_t'(~sample_ws);

  assign w_push = w_cap & (r_state == HAVE_L) & (w_ch == CH_RIGHT);
  assign w_pop  = m.m_valid & m.m_ready;
  assign w_drop = w_push & w_full & ~w_pop;
  assign w_serr = w_cap & (((r_state == WAIT_L) & (w_ch == CH_RIGHT)) |
                           ((r_state == HAVE_L) & (w_ch == CH_LEFT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_L;
      r_valid_q   <= 1'b0;
      r_left_hold <= '0;
      r_overflow  <= 1'b0;
      r_sync_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_valid_q <= sample_valid;
      if (w_cap) begin
        if (w_ch == CH_LEFT) begin
          r_left_hold <= sample_data;
          r_state     <= HAVE_L;
        end else begin
          r_state     <= WAIT_L;
        end
      end
      if (clear) begin
        r_overflow  <= 1'b0;
        r_sync_err  <= 1'b0;
        r_err_count <= '0;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        if (w_serr) r_sync_err <= 1'b1;
        if ((w_drop | w_serr) && (r_err_count != 8'hFF))
          r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2 * DATA_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({r_left_hold, sample_data}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign m.m_valid = ~w_empty;
  assign m.m_left  = w_rdata[2*DATA_SIZE-1:DATA_SIZE];
  assign m.m_right = w_rdata[DATA_SIZE-1:0];

  assign overflow  = r_overflow;
  assign sync_err  = r_sync_err;
  assign err_count = r_err_count;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_i2s_frame_fifo.sv
// Directed bench for i2s_frame_fifo: a small pairing model feeds an expected
// frame queue that is compared against the stream output as frames drain.
module tb_i2s_frame_fifo;
  import i2s_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int FW    = 2 * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] sample_data  = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ws    = 1'b0;
  logic          clear        = 1'b0;
  logic [4:0]    level;
  logic          overflow;
  logic          sync_err;
  logic [7:0]    err_count;
  pair_state_t   dbg_state;

  i2s_frame_fifo_if #(.DATA_SIZE(DW)) m_if ();

  i2s_frame_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ws    (sample_ws),
    .clear        (clear),
    .m            (m_if),
    .level        (level),
    .overflow     (overflow),
    .sync_err     (sync_err),
    .err_count    (err_count),
    .dbg_state    (dbg_state)
  );

  // scoreboard and model
  logic [FW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_err  = 0;
  bit            exp_ovf  = 0;
  bit            exp_serr = 0;
  bit            mdl_have_l = 0;
  logic [DW-1:0] mdl_hold = '0;
  logic [DW-1:0] lx, rx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic check_status(input string tag);
    check({tag, "/level"},    64'(level),       64'(exp_q.size()));
    check({tag, "/m_valid"},  64'(m_if.m_valid), 64'(exp_q.size() != 0));
    check({tag, "/overflow"}, 64'(overflow),    64'(exp_ovf));
    check({tag, "/sync_err"}, 64'(sync_err),    64'(exp_serr));
    check({tag, "/err_cnt"},  64'(err_count),   64'(exp_err));
    check({tag, "/state"},    64'(dbg_state),   64'(mdl_have_l ? HAVE_L : WAIT_L));
    if (exp_q.size() != 0)
      check({tag, "/head"}, 64'({m_if.m_left, m_if.m_right}), 64'(exp_q[0]));
    else
      check({tag, "/head0"}, 64'({m_if.m_left, m_if.m_right}), 64'(0));
  endtask

  // driver tasks
  task automatic drive_sample(input logic [DW-1:0] d, input logic ws, input int hold);
    @(negedge clk);
    sample_data  = d;
    sample_ws    = ws;
    sample_valid = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic send_left(input logic [DW-1:0] d, input int hold);
    drive_sample(d, 1'b1, hold);
    if (mdl_have_l) begin
      exp_serr = 1;
      bump_err();
    end
    mdl_hold   = d;
    mdl_have_l = 1;
  endtask

  task automatic send_right(input logic [DW-1:0] d);
    drive_sample(d, 1'b0, 1);
    if (!mdl_have_l) begin
      exp_serr = 1;
      bump_err();
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({mdl_hold, d});
      else begin
        exp_ovf = 1;
        bump_err();
      end
      mdl_have_l = 0;
    end
  endtask

  task automatic send_random_frame();
    send_left(DW'($urandom_range(0, 32'hFF_FFFF)), 1);
    send_right(DW'($urandom_range(0, 32'hFF_FFFF)));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_ovf  = 0;
    exp_serr = 0;
    exp_err  = 0;
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_if.m_ready = 1'b1;
      if (exp_q.size() == 0) break;
      check({tag, "/pop_valid"}, 64'(m_if.m_valid), 64'(1));
      check({tag, "/pop_data"}, 64'({m_if.m_left, m_if.m_right}), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    m_if.m_ready = 1'b0;
    check_status({tag, "/after"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_if.m_ready = 1'b0;

    // reset state, checked while reset is held
    #12;
    check_status("reset");
    @(negedge clk);
    rst = 1'b0;

    // basic pairing: L then R, one frame one cycle after the R capture
    send_left(24'h123456, 1);
    check_status("basic_l");
    send_right(24'hABCDEF);
    check_status("basic_r");
    check("basic_left",  64'(m_if.m_left),  64'(24'h123456));
    check("basic_right", 64'(m_if.m_right), 64'(24'hABCDEF));
    drain(1, "basic_drain");

    // held valid is one capture; repeated left overwrites and flags sync_err
    send_left(24'h111111, 5);
    check_status("hold5");
    send_left(24'h222222, 1);
    check_status("double_l");
    send_right(24'h333333);
    check_status("double_l_r");
    check("double_l_frame", 64'({m_if.m_left, m_if.m_right}), 64'({24'h222222, 24'h333333}));
    drain(1, "double_drain");
    pulse_clear();
    check_status("clear1");

    // overflow: DEPTH+2 frames with no consumer
    for (int i = 0; i < DEPTH + 2; i++) send_random_frame();
    check_status("overflow");
    check("overflow_err2", 64'(err_count), 64'(2));
    pulse_clear();
    check_status("clear_full");

    // full FIFO, push and pop in the same cycle
    lx = 24'hC0FFEE;
    rx = 24'hBEEF01;
    send_left(lx, 1);
    @(negedge clk);
    sample_data  = rx;
    sample_ws    = 1'b0;
    sample_valid = 1'b1;
    m_if.m_ready = 1'b1;
    check("simul_head", 64'({m_if.m_left, m_if.m_right}), 64'(exp_q[0]));
    void'(exp_q.pop_front());
    exp_q.push_back({lx, rx});
    mdl_have_l = 0;
    @(negedge clk);
    sample_valid = 1'b0;
    m_if.m_ready = 1'b0;
    check_status("simul");
    drain(DEPTH, "simul_drain");

    // asynchronous reset mid-frame with frames buffered
    for (int i = 0; i < 3; i++) send_random_frame();
    send_left(24'h5A5A5A, 1);
    check_status("pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    mdl_have_l = 0;
    exp_ovf = 0;
    exp_serr = 0;
    exp_err = 0;
    check_status("async_rst");
    @(negedge clk);
    rst = 1'b0;
    send_right(24'h777777);
    check_status("post_rst_r");

    // clear with overflow set and err_count 7
    for (int i = 0; i < DEPTH + 2; i++) send_random_frame();
    for (int i = 0; i < 4; i++) send_right(DW'(i));
    check_status("pre_clear7");
    check("err7", 64'(err_count), 64'(7));
    pulse_clear();
    check_status("clear7");
    drain(DEPTH, "clear7_drain");

    // err_count saturation
    for (int i = 0; i < 260; i++) send_right(DW'(i));
    check_status("saturate");
    check("sat255", 64'(err_count), 64'(255));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
